// File: rtl/cnn_frame_streamer_if.sv
// Load-side and AXI-Stream-side signals of cnn_frame_streamer.
// The master modport is the streamer's own view; slave is the source/sink side.
interface cnn_frame_streamer_if #(
  parameter int DATA_W    = 16,
  parameter int N_SAMPLES = 1024,
  parameter int IDX_W     = 10
);
  logic [DATA_W*N_SAMPLES-1:0] frame_in;
  logic                        load_valid;
  logic                        load_ready;
  logic                        abort;
  logic [DATA_W-1:0]           m_tdata;
  logic [IDX_W-1:0]            m_tuser;
  logic                        m_tlast;
  logic                        m_tvalid;
  logic                        m_tready;
  logic                        busy;
  logic                        done;

  modport master (
    input  frame_in, load_valid, abort, m_tready,
    output load_ready, m_tdata, m_tuser, m_tlast, m_tvalid, busy, done
  );

  modport slave (
    output frame_in, load_valid, abort, m_tready,
    input  load_ready, m_tdata, m_tuser, m_tlast, m_tvalid, busy, done
  );
endinterface

// File: rtl/cnn_frame_streamer.sv
// Replays one packed frame (sample 0 = MSB word) as an AXI-Stream, one sample per beat.
// Optional CNN_FRAME_STREAMER_CNT_EN adds a 16-bit completed-frame counter port frame_cnt.
module cnn_frame_streamer #(
  parameter int DATA_W    = 16,
  parameter int N_SAMPLES = 1024,
  parameter int IDX_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef CNN_FRAME_STREAMER_CNT_EN
  cnn_frame_streamer_if.master  bus,
  output logic [15:0]           frame_cnt
`else
  cnn_frame_streamer_if.master  bus
`endif
);
  localparam int FRAME_W = DATA_W * N_SAMPLES;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [IDX_W-1:0]   idx_q;
  logic               done_q;
  logic               load_hs, beat_hs, last_beat, last_hs;

  always_comb begin
    load_hs   = (state_q == IDLE) && bus.load_valid;
    beat_hs   = (state_q == STREAM) && bus.m_tready;
    last_beat = (idx_q == IDX_W'(N_SAMPLES - 1));
    last_hs   = beat_hs && last_beat;
    state_d   = state_q;
    unique case (state_q)
      IDLE:   if (load_hs) state_d = STREAM;
      // A last-beat handshake wins over a coincident abort (done still pulses)
      STREAM: if (last_hs || bus.abort) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_hs;
      if (load_hs)
        idx_q <= '0;
      else if (beat_hs && !last_beat)
        idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Frame store needs no reset: m_tdata is gated whenever no beat is valid
  always_ff @(posedge clk) begin
    if (load_hs)
      frame_q <= bus.frame_in;
    else if (beat_hs)
      frame_q <= frame_q << DATA_W;
  end

  always_comb begin
    bus.load_ready = (state_q == IDLE);
    bus.m_tvalid   = (state_q == STREAM);
    bus.busy       = (state_q == STREAM);
    bus.m_tlast    = (state_q == STREAM) && last_beat;
    bus.m_tdata    = (state_q == STREAM) ? frame_q[FRAME_W-1 -: DATA_W] : '0;
    bus.m_tuser    = (state_q == STREAM) ? idx_q : '0;
    bus.done       = done_q;
  end

`ifdef CNN_FRAME_STREAMER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt <= '0;
    else if (last_hs)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Scoreboard bench for cnn_frame_streamer: stimulus queues expected beats, a negedge monitor checks.
module tb_cnn_frame_streamer;
  localparam int DATA_W    = 16;
  localparam int N_SAMPLES = 1024;
  localparam int IDX_W     = 10;
  localparam int FRAME_W   = DATA_W * N_SAMPLES;

  typedef struct {
    logic [DATA_W-1:0] d;
    int unsigned       u;
    bit                l;
  } beat_t;

  logic clk;
  logic reset;
`ifdef CNN_FRAME_STREAMER_CNT_EN
  logic [15:0] frame_cnt;
`endif

  cnn_frame_streamer_if #(.DATA_W(DATA_W), .N_SAMPLES(N_SAMPLES), .IDX_W(IDX_W)) bus ();

  cnn_frame_streamer #(.DATA_W(DATA_W), .N_SAMPLES(N_SAMPLES), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CNN_FRAME_STREAMER_CNT_EN
    .bus       (bus),
    .frame_cnt (frame_cnt)
`else
    .bus       (bus)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_pass  = 0;
  int    n_total = 0;
  beat_t exp_q[$];
  bit    mon_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- monitor / reference model ----------------
  bit                streaming    = 0;
  bit                prev_last_hs = 0;
  bit                prev_rst     = 1;
  bit                prev_stall   = 0;
  logic [DATA_W-1:0] prev_d;
  logic [IDX_W-1:0]  prev_u;
  logic              prev_l;

  always @(negedge clk) begin
    if (mon_en) begin
      bit    hs, last_now;
      beat_t e;
      chk("load_ready", {31'd0, bus.load_ready}, {31'd0, !streaming});
      chk("tvalid",     {31'd0, bus.m_tvalid},   {31'd0, streaming});
      chk("busy",       {31'd0, bus.busy},       {31'd0, streaming});
      chk("done",       {31'd0, bus.done},       {31'd0, prev_last_hs && !prev_rst});
      if (!bus.m_tvalid) chk("tlast_idle", {31'd0, bus.m_tlast}, 32'd0);
      if (prev_rst) begin
        chk("rst_tdata", {16'd0, bus.m_tdata}, 32'd0);
        chk("rst_tuser", {22'd0, bus.m_tuser}, 32'd0);
      end
      if (prev_stall) begin
        chk("stall_tdata", {16'd0, bus.m_tdata}, {16'd0, prev_d});
        chk("stall_tuser", {22'd0, bus.m_tuser}, {22'd0, prev_u});
        chk("stall_tlast", {31'd0, bus.m_tlast}, {31'd0, prev_l});
      end
      hs       = bus.m_tvalid && bus.m_tready && !reset;
      last_now = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: tuser %0d tdata %0h, no beat expected", bus.m_tuser, bus.m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", {16'd0, bus.m_tdata}, {16'd0, e.d});
          chk("beat_tuser", {22'd0, bus.m_tuser}, e.u);
          chk("beat_tlast", {31'd0, bus.m_tlast}, {31'd0, e.l});
          last_now = e.l;
        end
      end
      if (reset)           streaming = 0;
      else if (!streaming) streaming = bus.load_valid;
      else if (last_now || bus.abort) streaming = 0;
      prev_last_hs = last_now;
      prev_rst     = reset;
      prev_stall   = bus.m_tvalid && !bus.m_tready && !bus.abort && !reset;
      prev_d       = bus.m_tdata;
      prev_u       = bus.m_tuser;
      prev_l       = bus.m_tlast;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Builds a frame (MSB word = sample 0) and queues the beats expected to transfer.
  task automatic build(input bit counting, input int n_push, output logic [FRAME_W-1:0] f);
    logic [DATA_W-1:0] s;
    beat_t b;
    f = '0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      s = counting ? DATA_W'(k + 1) : DATA_W'($urandom);
      f[FRAME_W-1-k*DATA_W -: DATA_W] = s;
      if (k < n_push) begin
        b.d = s;
        b.u = k;
        b.l = (k == N_SAMPLES - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return cyc[0];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // cut_kind: 0 abort with stall, 1 reset with stall, 2 abort with ready (last beat)
  task automatic run_frame(input bit counting, input int rmode, input int cut_at,
                           input int cut_kind, input bit idle_abort, input bit check_lat);
    logic [FRAME_W-1:0] f;
    int cyc;
    bit finished;
    int n_push;
    n_push = (cut_at < 0 || cut_kind == 2) ? N_SAMPLES : cut_at;
    build(counting, n_push, f);
    bus.frame_in   = f;
    bus.load_valid = 1'b1;
    bus.abort      = idle_abort;
    bus.m_tready   = 1'b0;
    step();
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;
    cyc      = 1;
    finished = 0;
    for (int c = 0; c < 6000; c++) begin
      if (bus.done) begin
        if (check_lat) chk("done_latency", cyc, 32'd1025);
        finished = 1;
        break;
      end
      if (cut_at >= 0 && bus.m_tvalid && int'(bus.m_tuser) == cut_at) begin
        if (cut_kind == 1) begin reset = 1'b1; bus.m_tready = 1'b0; end
        else if (cut_kind == 0) begin bus.abort = 1'b1; bus.m_tready = 1'b0; end
        else begin bus.abort = 1'b1; bus.m_tready = 1'b1; end
        step();
        reset     = 1'b0;
        bus.abort = 1'b0;
        cyc++;
        if (cut_kind != 2) begin
          finished = 1;
          step();
          step();
          break;
        end
        continue;
      end
      bus.m_tready = ready_for(rmode, cyc);
      step();
      cyc++;
    end
    if (!finished) fail("frame_timeout");
  endtask

  task automatic back_to_back();
    logic [FRAME_W-1:0] fa, fb;
    int n;
    build(0, N_SAMPLES, fa);
    build(0, N_SAMPLES, fb);
    bus.frame_in   = fa;
    bus.load_valid = 1'b1;
    bus.m_tready   = 1'b1;
    step();
    bus.frame_in = fb;
    n = 0;
    while (!bus.done && n < 3000) begin step(); n++; end
    if (!bus.done) fail("b2b_a_timeout");
    step();
    bus.load_valid = 1'b0;
    chk("b2b_first_valid", {31'd0, bus.m_tvalid}, 32'd1);
    chk("b2b_first_tuser", {22'd0, bus.m_tuser}, 32'd0);
    n = 0;
    while (!bus.done && n < 3000) begin step(); n++; end
    if (!bus.done) fail("b2b_b_timeout");
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_in   = '0;
    bus.load_valid = 1'b0;
    bus.abort      = 1'b0;
    bus.m_tready   = 1'b0;
    step();
    mon_en = 1;
    step();
    step();
    reset = 1'b0;
    step();
    run_frame(1, 0, -1,   0, 0, 1);
    run_frame(0, 1, -1,   0, 0, 0);
    back_to_back();
    run_frame(0, 2, 500,  0, 0, 0);
    run_frame(0, 2, -1,   0, 0, 0);
    run_frame(0, 0, 1023, 2, 0, 0);
    run_frame(0, 1, 300,  1, 0, 0);
    run_frame(0, 2, -1,   0, 1, 0);
    step();
    step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
